// File: rtl/instr_buffer.sv
// Instruction buffer: loads one program from the front-end stage, then serves
// single-cycle fetches to the sequencer until the scalar unit terminates it.
package instr_buffer_pkg;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned ISSUE_W = 4;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [ID_W-1:0]    id_t;
    typedef logic [ISSUE_W-1:0] mpu_issue_no_t;
endpackage

module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned WIDTH_PTR = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_We,
    input  logic                 I_Wr_End,
    input  id_t                  I_ThreadID,
    input  instr_t               I_Instr,
    input  mpu_issue_no_t        I_IssueNo,
    input  logic                 I_Term,
    input  logic                 I_Req_Fetch,
    input  logic [WIDTH_PTR-1:0] I_PC,
    output logic                 O_Full,
    output logic                 O_Ready,
    output logic                 O_Valid,
    output instr_t               O_Instr,
    output id_t                  O_ThreadID,
    output mpu_issue_no_t        O_IssueNo,
    output logic [WIDTH_PTR:0]   O_Length,
    output logic                 O_Bad_PC
);

    localparam int unsigned CNT_W = WIDTH_PTR + 1;

    typedef enum logic [1:0] {EMPTY, LOAD, READY, RUN} state_e;

    state_e         state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    id_t            tid_q, tid_d;
    mpu_issue_no_t  issue_q, issue_d;
    logic           valid_q, valid_d;
    logic           bad_pc_q, bad_pc_d;
    instr_t         instr_q, instr_d;
    logic           we_c;
    logic           full_c;
    logic           ready_c;
    logic           pc_in_range_c;

    instr_t mem_q [DEPTH];

    assign ready_c       = (state_q == READY) || (state_q == RUN);
    assign full_c        = (count_q == CNT_W'(DEPTH)) || ready_c;
    assign pc_in_range_c = {1'b0, I_PC} < count_q;

    // Load/run control; the write index is the running count, so it never wraps.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tid_d   = tid_q;
        issue_d = issue_q;
        we_c    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (!I_Term && I_We) begin
                    we_c    = 1'b1;
                    count_d = CNT_W'(1);
                    tid_d   = I_ThreadID;
                    issue_d = I_IssueNo;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!I_Term) begin
                    if (I_We && !full_c) begin
                        we_c    = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                    if (I_Wr_End) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (!I_Term && I_Req_Fetch) begin
                    state_d = RUN;
                end
            end
            RUN: begin
            end
            default: state_d = EMPTY;
        endcase
        if (I_Term && (state_q != EMPTY)) begin
            state_d = EMPTY;
            count_d = '0;
            tid_d   = '0;
            issue_d = '0;
            we_c    = 1'b0;
        end
    end

    // Fetch result is presented one cycle after the request.
    always_comb begin
        valid_d  = I_Req_Fetch && ready_c && pc_in_range_c;
        bad_pc_d = I_Req_Fetch && ready_c && !pc_in_range_c;
        instr_d  = instr_q;
        if (valid_d) begin
            instr_d = mem_q[I_PC];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= EMPTY;
            count_q  <= '0;
            tid_q    <= '0;
            issue_q  <= '0;
            valid_q  <= 1'b0;
            bad_pc_q <= 1'b0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tid_q    <= tid_d;
            issue_q  <= issue_d;
            valid_q  <= valid_d;
            bad_pc_q <= bad_pc_d;
            instr_q  <= instr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (we_c) begin
            mem_q[count_q[WIDTH_PTR-1:0]] <= I_Instr;
        end
    end

    assign O_Full     = full_c;
    assign O_Ready    = ready_c;
    assign O_Valid    = valid_q;
    assign O_Bad_PC   = bad_pc_q;
    assign O_Instr    = instr_q;
    assign O_ThreadID = tid_q;
    assign O_IssueNo  = issue_q;
    assign O_Length   = count_q;

endmodule

// File: doc/instr_buffer.md
INSTR_BUFFER -- requirements
Module: instr_buffer

Interface
REQ-001 Parameter DEPTH, default 64: instruction-buffer entries; power of two, minimum 4.
REQ-002 Parameter WIDTH_PTR, default $clog2(DEPTH): pointer width.
REQ-003 clock  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 I_We  input  1  write-enable from front-end stage.
REQ-006 I_Wr_End  input  1  end of program load from front-end stage.
REQ-007 I_ThreadID  input  id_t  thread ID accompanying writes.
REQ-008 I_Instr  input  instr_t  instruction to store.
REQ-009 I_IssueNo  input  mpu_issue_no_t  MPU issue number of loaded program.
REQ-010 I_Term  input  1  termination from scalar unit; releases buffer.
REQ-011 I_Req_Fetch  input  1  fetch request from sequencer.
REQ-012 I_PC  input  WIDTH_PTR  fetch address.
REQ-013 O_Full  output  1  buffer cannot accept writes; to front-end stage.
REQ-014 O_Ready  output  1  program fully loaded, fetch permitted.
REQ-015 O_Valid  output  1  O_Instr valid for the fetch issued the previous cycle.
REQ-016 O_Instr  output  instr_t  fetched instruction.
REQ-017 O_ThreadID  output  id_t  thread ID latched at load.
REQ-018 O_IssueNo  output  mpu_issue_no_t  issue number latched at load, for commit.
REQ-019 O_Length  output  WIDTH_PTR+1  number of stored instructions.
REQ-020 O_Bad_PC  output  1  one-cycle pulse: fetch with I_PC >= O_Length.

Function
REQ-021 FSM states EMPTY, LOAD, READY, RUN; reset state EMPTY.
REQ-022 EMPTY: I_We -> write entry 0, count=1, latch I_ThreadID and I_IssueNo, go LOAD; I_Wr_End without I_We ignored, stay EMPTY.
REQ-023 LOAD: I_We & count<DEPTH -> write at wr_ptr, wr_ptr+1, count+1; I_Wr_End -> READY next cycle.
REQ-024 I_We and I_Wr_End in same LOAD cycle: instruction written first, then READY; O_Length includes it.
REQ-025 READY: first I_Req_Fetch -> RUN; O_Ready=1 in READY and RUN.
REQ-026 RUN: I_Term -> EMPTY next cycle; wr_ptr, count, O_Length, O_ThreadID, O_IssueNo cleared to 0.
REQ-027 I_Term in LOAD or READY also -> EMPTY with same clearing; I_Term in EMPTY no effect.
REQ-028 O_Full = (count==DEPTH) | READY | RUN; registered-free, combinational from state and count.
REQ-029 I_We while O_Full: write dropped, pointer and count unchanged.
REQ-030 I_Term and I_We same cycle: I_Term wins, write dropped.
REQ-031 Fetch latency 1: I_Req_Fetch & O_Ready & I_PC<O_Length at cycle N -> O_Valid=1, O_Instr=mem[I_PC] at N+1.
REQ-032 Fetch when not O_Ready: O_Valid=0 next cycle, no O_Bad_PC.
REQ-033 Fetch with O_Ready & I_PC>=O_Length: O_Valid=0, O_Bad_PC=1 at N+1 for one cycle.
REQ-034 O_Valid deasserts the cycle after I_Req_Fetch falls; O_Instr holds last value.
REQ-035 Back-to-back fetches each cycle supported, one result per cycle.
REQ-036 count width WIDTH_PTR+1; wr_ptr never wraps; count saturates at DEPTH.
REQ-037 Storage memory contents not reset; only control state and outputs reset.

Reset
REQ-038 reset=0 asynchronously forces EMPTY; O_Full=0, O_Ready=0, O_Valid=0, O_Bad_PC=0, O_Instr=0, O_ThreadID=0, O_IssueNo=0, O_Length=0.
REQ-039 reset assertion mid-LOAD or mid-RUN discards program; after release, buffer behaves as freshly reset.

Verification
REQ-040 Load 5 instrs (IssueNo=3, ThreadID=7), Wr_End with 5th -> O_Length=5, O_Ready=1, O_Full=1, O_IssueNo=3, O_ThreadID=7.
REQ-041 Fetch PC=0..4 consecutive cycles -> O_Valid=1 for 5 cycles, O_Instr in write order; PC=5 -> O_Bad_PC=1, O_Valid=0.
REQ-042 DEPTH=4, write 6 without Wr_End -> O_Full=1 after 4th, writes 5-6 dropped, O_Length=4 after Wr_End.
REQ-043 In RUN assert I_Term together with I_We -> EMPTY, O_Full=0, O_Length=0, no write.
REQ-044 Fetch in EMPTY/LOAD -> O_Valid=0, O_Bad_PC=0.
REQ-045 reset=0 mid-RUN between clock edges -> outputs zero immediately; reload of 2 instrs succeeds.
